// File: rtl/uart_frame_ctrl_pkg.sv
// Shared types for the UART frame controller: state encoding and default header byte.
package uart_frame_ctrl_pkg;

   // Start-of-frame byte that opens every command frame.
   localparam logic [7:0] UART_HEADER = 8'hA5;

   // One-hot frame sequencer states; also exported on the state_str debug port.
   typedef enum logic [4:0] {
      S_IDLE    = 5'b00001,
      S_LEN     = 5'b00010,
      S_PAYLOAD = 5'b00100,
      S_CHECK   = 5'b01000,
      S_DRAIN   = 5'b10000
   } state_t;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x 8 register file, one synchronous write port and one
// combinational read port. Contents are not reset; the controller only reads
// entries that the current frame has written.
module uart_frame_buf #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clock,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [7:0]        wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [7:0]        rdata
);

   logic [7:0] mem_q [DEPTH];

   // Store one payload byte per write strobe.
   always_ff @(posedge clock) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frame sequencer between uart_rx and the command decoder.
// Accepts HEADER, LEN, LEN payload bytes and an XOR checksum byte, buffers the
// payload, and on a good checksum streams it out in arrival order. Bad length,
// bad checksum and inter-byte timeout drop the frame with a one-cycle error
// pulse plus rx_flush to resynchronise the receiver.
//
// Output handshake: a byte moves when out_valid && out_ready are both high at a
// rising clock edge. While out_valid is high and out_ready is low, out_data,
// out_last and frame_len hold their values. out_valid is decoded from the state
// register only, so it never depends combinationally on out_ready.
module uart_frame_ctrl
   import uart_frame_ctrl_pkg::*;
#(
   parameter logic [7:0] HEADER        = UART_HEADER,
   parameter int         MAX_LEN       = 16,
   parameter int         TIMEOUT_TICKS = 160,
   localparam int        LEN_W         = $clog2(MAX_LEN + 1)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             clock_en,
   input  logic             byte_valid,
   input  logic [7:0]       byte_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_data,
   output logic             out_last,
   output logic [LEN_W-1:0] frame_len,
   output logic             err_chk,
   output logic             err_len,
   output logic             err_timeout,
   output logic             overrun,
   output logic             rx_flush,
   output state_t           state_str
);

   localparam int                ADDR_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int                TCNT_W    = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [TCNT_W-1:0] TCNT_MAX  = TCNT_W'(TIMEOUT_TICKS);
   localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_TICKS - 1);
   localparam logic [7:0]        MAX_LEN_B = 8'(MAX_LEN);

   state_t            state_q, state_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  idx_q, idx_d;
   logic [LEN_W-1:0]  rd_idx_q, rd_idx_d;
   logic [TCNT_W-1:0] tcnt_q, tcnt_d;
   logic [7:0]        chk_q, chk_d;
   logic              err_chk_q, err_chk_d;
   logic              err_len_q, err_len_d;
   logic              err_timeout_q, err_timeout_d;
   logic              overrun_q, overrun_d;
   logic              rx_flush_q, rx_flush_d;

   logic              buf_we;
   logic [7:0]        buf_rdata;
   logic [LEN_W-1:0]  last_idx;
   logic              frame_active;
   logic              timeout_hit;

   uart_frame_buf #(
      .DEPTH  (MAX_LEN),
      .ADDR_W (ADDR_W)
   ) u_buf (
      .clock (clock),
      .we    (buf_we),
      .waddr (idx_q[ADDR_W-1:0]),
      .wdata (byte_data),
      .raddr (rd_idx_q[ADDR_W-1:0]),
      .rdata (buf_rdata)
   );

   assign last_idx     = len_q - LEN_W'(1);
   assign frame_active = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHECK);
   // A byte arriving on the expiring tick wins over the timeout.
   assign timeout_hit  = frame_active && clock_en && !byte_valid && (tcnt_q == TCNT_LAST);

   assign out_valid   = (state_q == S_DRAIN);
   assign out_data    = out_valid ? buf_rdata : 8'h00;
   assign out_last    = out_valid && (rd_idx_q == last_idx);
   assign frame_len   = len_q;
   assign err_chk     = err_chk_q;
   assign err_len     = err_len_q;
   assign err_timeout = err_timeout_q;
   assign overrun     = overrun_q;
   assign rx_flush    = rx_flush_q;
   assign state_str   = state_q;

   // Next-state, datapath updates and error pulse requests.
   always_comb begin
      state_d       = state_q;
      len_d         = len_q;
      idx_d         = idx_q;
      rd_idx_d      = rd_idx_q;
      chk_d         = chk_q;
      tcnt_d        = '0;
      err_chk_d     = 1'b0;
      err_len_d     = 1'b0;
      err_timeout_d = 1'b0;
      overrun_d     = 1'b0;
      buf_we        = 1'b0;

      // Inter-byte timer runs only while a frame is being received.
      if (frame_active && !byte_valid) begin
         tcnt_d = tcnt_q;
         if (clock_en && (tcnt_q != TCNT_MAX)) begin
            tcnt_d = tcnt_q + TCNT_W'(1);
         end
      end

      case (state_q)
         S_IDLE: begin
            if (byte_valid && (byte_data == HEADER)) begin
               state_d = S_LEN;
            end
         end
         S_LEN: begin
            if (byte_valid) begin
               if ((byte_data != 8'h00) && (byte_data <= MAX_LEN_B)) begin
                  len_d   = byte_data[LEN_W-1:0];
                  chk_d   = byte_data;
                  idx_d   = '0;
                  state_d = S_PAYLOAD;
               end else begin
                  err_len_d = 1'b1;
                  state_d   = S_IDLE;
               end
            end
         end
         S_PAYLOAD: begin
            if (byte_valid) begin
               buf_we = 1'b1;
               chk_d  = chk_q ^ byte_data;
               if (idx_q == last_idx) begin
                  state_d = S_CHECK;
               end else begin
                  idx_d = idx_q + LEN_W'(1);
               end
            end
         end
         S_CHECK: begin
            if (byte_valid) begin
               if ((chk_q ^ byte_data) == 8'h00) begin
                  rd_idx_d = '0;
                  state_d  = S_DRAIN;
               end else begin
                  err_chk_d = 1'b1;
                  state_d   = S_IDLE;
               end
            end
         end
         S_DRAIN: begin
            // Bytes from the receiver cannot be held here; they are dropped and flagged.
            overrun_d = byte_valid;
            if (out_ready) begin
               if (rd_idx_q == last_idx) begin
                  rd_idx_d = '0;
                  state_d  = S_IDLE;
               end else begin
                  rd_idx_d = rd_idx_q + LEN_W'(1);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (timeout_hit) begin
         err_timeout_d = 1'b1;
         tcnt_d        = '0;
         state_d       = S_IDLE;
      end

      rx_flush_d = err_chk_d | err_len_d | err_timeout_d;
   end

   // State, counters and registered one-cycle pulses; reset aborts any frame.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         len_q         <= '0;
         idx_q         <= '0;
         rd_idx_q      <= '0;
         tcnt_q        <= '0;
         chk_q         <= 8'h00;
         err_chk_q     <= 1'b0;
         err_len_q     <= 1'b0;
         err_timeout_q <= 1'b0;
         overrun_q     <= 1'b0;
         rx_flush_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         len_q         <= len_d;
         idx_q         <= idx_d;
         rd_idx_q      <= rd_idx_d;
         tcnt_q        <= tcnt_d;
         chk_q         <= chk_d;
         err_chk_q     <= err_chk_d;
         err_len_q     <= err_len_d;
         err_timeout_q <= err_timeout_d;
         overrun_q     <= overrun_d;
         rx_flush_q    <= rx_flush_d;
      end
   end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Bench for uart_frame_ctrl: directed frames followed by randomized frames,
// all checked against a frame-level reference model.
module tb_uart_frame_ctrl;
   import uart_frame_ctrl_pkg::*;

   localparam int MAX_LEN       = 16;
   localparam int LEN_W         = $clog2(MAX_LEN + 1);
   localparam int TIMEOUT_TICKS = 160;
   localparam logic [7:0] HDR   = 8'hA5;

   logic             clock = 1'b0;
   logic             reset_n;
   logic             clock_en;
   logic             byte_valid;
   logic [7:0]       byte_data;
   logic             out_valid;
   logic             out_ready;
   logic [7:0]       out_data;
   logic             out_last;
   logic [LEN_W-1:0] frame_len;
   logic             err_chk;
   logic             err_len;
   logic             err_timeout;
   logic             overrun;
   logic             rx_flush;
   state_t           state_str;

   uart_frame_ctrl #(
      .HEADER        (HDR),
      .MAX_LEN       (MAX_LEN),
      .TIMEOUT_TICKS (TIMEOUT_TICKS)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .clock_en    (clock_en),
      .byte_valid  (byte_valid),
      .byte_data   (byte_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_last    (out_last),
      .frame_len   (frame_len),
      .err_chk     (err_chk),
      .err_len     (err_len),
      .err_timeout (err_timeout),
      .overrun     (overrun),
      .rx_flush    (rx_flush),
      .state_str   (state_str)
   );

   // ---------------- clock / reset ----------------
   always #5 clock = ~clock;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   typedef enum int {K_NONE, K_OK, K_LEN, K_CHK} kind_t;

   int               checks = 0;
   int               errors = 0;
   int               ready_pct = 100;

   logic [7:0]       tx_q[$];
   logic [7:0]       exp_q[$];
   kind_t            exp_kind;
   int               exp_len;

   logic [7:0]       got_data[$];
   logic             got_last[$];
   logic [LEN_W-1:0] got_len[$];
   int               n_chk, n_len, n_to, n_ovr;
   int               flush_bad, hold_bad, idle_bad;
   logic             hold_prev;
   logic [7:0]       pd;
   logic             pl;
   logic [LEN_W-1:0] pfl;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_obs();
      got_data.delete();
      got_last.delete();
      got_len.delete();
      n_chk = 0; n_len = 0; n_to = 0; n_ovr = 0;
      flush_bad = 0; hold_bad = 0; idle_bad = 0;
      hold_prev = 1'b0;
   endtask

   // ---------------- reference model ----------------
   // Interprets tx_q as a frame: skip to the header, read LEN, payload and CHK,
   // and decide by the frame rules what the consumer should receive.
   task automatic model_frame();
      int i;
      logic [7:0] x;
      exp_q.delete();
      exp_kind = K_NONE;
      exp_len  = 0;
      i = 0;
      while (i < tx_q.size() && tx_q[i] != HDR) i++;
      if (i + 1 >= tx_q.size()) return;
      exp_len = int'(tx_q[i+1]);
      if (exp_len == 0 || exp_len > MAX_LEN) begin
         exp_kind = K_LEN;
         return;
      end
      if (i + 2 + exp_len >= tx_q.size()) return;
      x = tx_q[i+1];
      for (int k = 0; k < exp_len; k++) begin
         x = x ^ tx_q[i+2+k];
         exp_q.push_back(tx_q[i+2+k]);
      end
      x = x ^ tx_q[i+2+exp_len];
      if (x == 8'h00) begin
         exp_kind = K_OK;
      end else begin
         exp_kind = K_CHK;
         exp_q.delete();
      end
   endtask

   // ---------------- driver ----------------
   // One clock cycle: drive inputs, sample the handshake before the edge, then
   // sample the registered pulses just after the edge.
   task automatic step(input logic bv, input logic [7:0] bd, input logic en);
      byte_valid = bv;
      byte_data  = bd;
      clock_en   = en;
      out_ready  = ($urandom_range(0, 99) < ready_pct);
      #1;
      if (hold_prev && (out_valid !== 1'b1 || out_data !== pd || out_last !== pl || frame_len !== pfl))
         hold_bad++;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         got_data.push_back(out_data);
         got_last.push_back(out_last);
         got_len.push_back(frame_len);
      end
      hold_prev = (out_valid === 1'b1) && !out_ready;
      pd  = out_data;
      pl  = out_last;
      pfl = frame_len;
      @(posedge clock);
      #1;
      if (err_chk === 1'b1) n_chk++;
      if (err_len === 1'b1) n_len++;
      if (err_timeout === 1'b1) n_to++;
      if (overrun === 1'b1) n_ovr++;
      if (rx_flush !== (err_chk | err_len | err_timeout)) flush_bad++;
      if ((err_chk | err_len | err_timeout) === 1'b1 && state_str !== S_IDLE) idle_bad++;
   endtask

   task automatic step_r(input logic bv, input logic [7:0] bd);
      step(bv, bd, ($urandom_range(0, 3) == 0));
   endtask

   task automatic send_tx(input int max_gap);
      for (int i = 0; i < tx_q.size(); i++) begin
         step_r(1'b1, tx_q[i]);
         if (i != tx_q.size() - 1) repeat ($urandom_range(0, max_gap)) step_r(1'b0, 8'h00);
      end
   endtask

   task automatic verify(input string tag, input int exp_to, input int exp_ovr);
      int n;
      check({tag, "_count"}, got_data.size(), exp_q.size());
      n = (got_data.size() < exp_q.size()) ? got_data.size() : exp_q.size();
      for (int k = 0; k < n; k++) begin
         check({tag, "_data"}, got_data[k], exp_q[k]);
         check({tag, "_last"}, got_last[k], (k == exp_q.size() - 1));
         check({tag, "_flen"}, got_len[k], exp_len);
      end
      check({tag, "_err_chk"}, n_chk, (exp_kind == K_CHK));
      check({tag, "_err_len"}, n_len, (exp_kind == K_LEN));
      check({tag, "_err_to"}, n_to, exp_to);
      check({tag, "_overrun"}, n_ovr, exp_ovr);
      check({tag, "_flush"}, flush_bad, 0);
      check({tag, "_hold"}, hold_bad, 0);
      check({tag, "_err_idle"}, idle_bad, 0);
   endtask

   // After the last frame byte: check first-valid latency, drain, then score.
   task automatic finish_frame(input string tag, input int exp_to, input int exp_ovr);
      int guard;
      check({tag, "_valid_lat"}, out_valid, (exp_kind == K_OK));
      guard = 0;
      while (out_valid === 1'b1 && guard < 500) begin
         step_r(1'b0, 8'h00);
         guard++;
      end
      check({tag, "_drain_bound"}, (guard < 500), 1);
      repeat (2) step_r(1'b0, 8'h00);
      check({tag, "_idle"}, state_str, S_IDLE);
      verify(tag, exp_to, exp_ovr);
   endtask

   task automatic run_frame(input string tag, input int max_gap, input int pct);
      clear_obs();
      model_frame();
      ready_pct = pct;
      send_tx(max_gap);
      finish_frame(tag, 0, 0);
   endtask

   // Random frame: optional junk, header, LEN and (for a legal LEN) payload and CHK.
   task automatic build_frame(input int len, input logic corrupt);
      logic [7:0] b;
      logic [7:0] c;
      tx_q.delete();
      repeat ($urandom_range(0, 2)) begin
         b = 8'($urandom);
         if (b == HDR) b = 8'h5A;
         tx_q.push_back(b);
      end
      tx_q.push_back(HDR);
      tx_q.push_back(8'(len));
      if (len >= 1 && len <= MAX_LEN) begin
         c = 8'(len);
         for (int k = 0; k < len; k++) begin
            b = 8'($urandom);
            c = c ^ b;
            tx_q.push_back(b);
         end
         if (corrupt) c = c ^ 8'($urandom_range(1, 255));
         tx_q.push_back(c);
      end
   endtask

   // ---------------- directed and random sequence ----------------
   initial begin
      int len;
      int r;
      int pct;
      logic [7:0] c;

      reset_n    = 1'b0;
      clock_en   = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      out_ready  = 1'b0;
      clear_obs();
      repeat (3) @(posedge clock);
      #1;
      check("reset_outs", {out_valid, out_last, out_data, frame_len, err_chk, err_len,
                           err_timeout, overrun, rx_flush}, 0);
      check("reset_state", state_str, S_IDLE);
      reset_n = 1'b1;

      // Good 3-byte frame, consumer always ready.
      tx_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
      run_frame("good3", 0, 100);

      // Same frame with a wrong checksum.
      tx_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
      run_frame("badchk", 0, 100);

      // Illegal lengths, then a good frame.
      tx_q = '{8'hA5, 8'h00};
      run_frame("len0", 0, 100);
      tx_q = '{8'hA5, 8'h11};
      run_frame("len17", 0, 100);
      tx_q = '{8'h3C, 8'hA5, 8'h01, 8'h7E, 8'h7F};
      run_frame("after_len", 1, 100);

      // Timeout: no byte for TIMEOUT_TICKS ticks inside the payload.
      tx_q = '{8'hA5, 8'h02, 8'h55};
      clear_obs();
      model_frame();
      step(1'b1, 8'hA5, 1'b0);
      step(1'b1, 8'h02, 1'b0);
      step(1'b1, 8'h55, 1'b0);
      repeat (TIMEOUT_TICKS - 1) step(1'b0, 8'h00, 1'b1);
      check("to_before_expiry", n_to, 0);
      step(1'b0, 8'h00, 1'b1);
      check("to_at_expiry", n_to, 1);
      check("to_state", state_str, S_IDLE);
      finish_frame("timeout", 1, 0);

      // Byte arriving on the expiring tick keeps the frame alive.
      c = 8'h02 ^ 8'h55 ^ 8'h66;
      tx_q = '{8'hA5, 8'h02, 8'h55, 8'h66, c};
      clear_obs();
      model_frame();
      step(1'b1, 8'hA5, 1'b0);
      step(1'b1, 8'h02, 1'b0);
      step(1'b1, 8'h55, 1'b0);
      repeat (TIMEOUT_TICKS - 1) step(1'b0, 8'h00, 1'b1);
      step(1'b1, 8'h66, 1'b1);
      repeat (TIMEOUT_TICKS - 1) step(1'b0, 8'h00, 1'b1);
      step(1'b1, c, 1'b1);
      finish_frame("to_edge", 0, 0);

      // Backpressure for 20 cycles with a header byte injected mid-drain.
      c = 8'h02 ^ 8'hC3 ^ 8'h3C;
      tx_q = '{8'hA5, 8'h02, 8'hC3, 8'h3C, c};
      clear_obs();
      model_frame();
      ready_pct = 0;
      send_tx(0);
      repeat (10) step(1'b0, 8'h00, 1'b0);
      step(1'b1, HDR, 1'b0);
      repeat (9) step(1'b0, 8'h00, 1'b0);
      check("stall_no_xfer", got_data.size(), 0);
      check("stall_overrun", n_ovr, 1);
      ready_pct = 100;
      finish_frame("stall", 0, 1);

      // Reset in the middle of a payload.
      clear_obs();
      step(1'b1, 8'hA5, 1'b0);
      step(1'b1, 8'h04, 1'b0);
      step(1'b1, 8'h01, 1'b0);
      step(1'b1, 8'h02, 1'b0);
      reset_n = 1'b0;
      #1;
      check("rst_pay_outs", {out_valid, out_last, out_data, frame_len, err_chk, err_len,
                             err_timeout, overrun, rx_flush}, 0);
      repeat (3) @(posedge clock);
      #1;
      check("rst_pay_hold", {out_valid, err_chk, err_len, err_timeout, overrun, rx_flush}, 0);
      reset_n = 1'b1;
      check("rst_pay_state", state_str, S_IDLE);
      c = 8'h04 ^ 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF;
      tx_q = '{8'hA5, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF, c};
      run_frame("post_rst", 1, 100);

      // Reset while draining: out_valid must drop without waiting for a clock.
      c = 8'h03 ^ 8'h01 ^ 8'h02 ^ 8'h04;
      tx_q = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h04, c};
      clear_obs();
      model_frame();
      ready_pct = 0;
      send_tx(0);
      check("rst_drain_pre", out_valid, 1);
      reset_n = 1'b0;
      #1;
      check("rst_drain_valid", out_valid, 0);
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      clear_obs();
      c = 8'h02 ^ 8'h99 ^ 8'h77;
      tx_q = '{8'hA5, 8'h02, 8'h99, 8'h77, c};
      run_frame("post_rst_drain", 0, 50);

      // Length boundaries.
      build_frame(MAX_LEN, 1'b0);
      run_frame("len_max", 1, 60);
      build_frame(1, 1'b0);
      run_frame("len_one", 1, 100);
      build_frame(MAX_LEN + 1, 1'b0);
      run_frame("len_over", 1, 100);

      // Randomized frames.
      for (int f = 0; f < 40; f++) begin
         r = int'($urandom_range(0, 9));
         case ($urandom_range(0, 2))
            0:       pct = 100;
            1:       pct = 50;
            default: pct = 20;
         endcase
         if (r == 0) begin
            len = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(MAX_LEN + 1, 255));
            build_frame(len, 1'b0);
         end else begin
            len = int'($urandom_range(1, MAX_LEN));
            build_frame(len, (r < 3));
         end
         run_frame($sformatf("rnd%0d", f), 3, pct);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
